// File: rtl/divmod_unit.sv
// Iterative restoring divider producing quotient and remainder over a start/busy/done handshake.
// Define DIVMOD_SIGNED_EN to add the signed_op port and signed (truncating) division.
module divmod_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef DIVMOD_SIGNED_EN
  input  logic             signed_op,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] dividend_reg;
  logic [WIDTH-1:0] divisor_reg;
  logic [WIDTH-1:0] partial_rem;
  logic [CNT_W-1:0] count;
  logic             neg_quo;
  logic             neg_rem;

  logic             dividend_neg;
  logic             divisor_neg;
  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] next_rem;
  logic [WIDTH-1:0] next_quo;

`ifdef DIVMOD_SIGNED_EN
  assign dividend_neg = signed_op & dividend[WIDTH-1];
  assign divisor_neg  = signed_op & divisor[WIDTH-1];
`else
  assign dividend_neg = 1'b0;
  assign divisor_neg  = 1'b0;
`endif

  // The core always divides magnitudes; signs are reapplied when results are loaded.
  assign dividend_mag = dividend_neg ? -dividend : dividend;
  assign divisor_mag  = divisor_neg  ? -divisor  : divisor;

  // One extra bit keeps the borrow when the divisor has its MSB set.
  assign shifted  = {partial_rem, dividend_reg[WIDTH-1]};
  assign diff     = shifted - {1'b0, divisor_reg};
  assign next_rem = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign next_quo = {dividend_reg[WIDTH-2:0], ~diff[WIDTH]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      quotient     <= '0;
      remainder    <= '0;
      div_by_zero  <= 1'b0;
      dividend_reg <= '0;
      divisor_reg  <= '0;
      partial_rem  <= '0;
      count        <= '0;
      neg_quo      <= 1'b0;
      neg_rem      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            dividend_reg <= dividend_mag;
            divisor_reg  <= divisor_mag;
            partial_rem  <= '0;
            count        <= '0;
            neg_quo      <= dividend_neg ^ divisor_neg;
            neg_rem      <= dividend_neg;
            busy         <= 1'b1;
            div_by_zero  <= 1'b0;
            // A zero divisor skips the iterations entirely and reports at once.
            if (divisor == '0) begin
              state       <= DONE;
              done        <= 1'b1;
              div_by_zero <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          partial_rem  <= next_rem;
          dividend_reg <= next_quo;
          count        <= count + CNT_W'(1);
          if (count == LAST_COUNT) begin
            state     <= DONE;
            done      <= 1'b1;
            quotient  <= neg_quo ? -next_quo : next_quo;
            remainder <= neg_rem ? -next_rem : next_rem;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divmod_unit.sv
// Scoreboard bench for divmod_unit: stimulus pushes expected results, a monitor per instance checks each done.
// Signed vectors are exercised only when DIVMOD_SIGNED_EN is defined.
module tb_divmod_unit;

  typedef struct {
    string       name;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          edge_idx;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start32 = 1'b0;
  logic [31:0] dividend32 = '0;
  logic [31:0] divisor32 = '0;
  logic        busy32, done32, dz32;
  logic [31:0] quotient32, remainder32;

  logic        start8 = 1'b0;
  logic [7:0]  dividend8 = '0;
  logic [7:0]  divisor8 = '0;
  logic        busy8, done8, dz8;
  logic [7:0]  quotient8, remainder8;

`ifdef DIVMOD_SIGNED_EN
  logic        signed_op32 = 1'b0;
  logic        signed_op8 = 1'b0;
`endif

  int   edge_cnt = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb32[$];
  exp_t sb8[$];

  divmod_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .dividend(dividend32), .divisor(divisor32),
`ifdef DIVMOD_SIGNED_EN
    .signed_op(signed_op32),
`endif
    .busy(busy32), .done(done32), .quotient(quotient32), .remainder(remainder32),
    .div_by_zero(dz32)
  );

  divmod_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .dividend(dividend8), .divisor(divisor8),
`ifdef DIVMOD_SIGNED_EN
    .signed_op(signed_op8),
`endif
    .busy(busy8), .done(done8), .quotient(quotient8), .remainder(remainder8),
    .div_by_zero(dz8)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Each done is matched against the oldest outstanding expectation, including its arrival edge.
  always @(negedge clk) begin : monitor32
    exp_t e;
    if (!rst && done32) begin
      if (sb32.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected_done32: got done with q=0x%08h, expected no done", quotient32);
      end else begin
        e = sb32.pop_front();
        check_output({e.name, ".quotient"}, quotient32, e.q);
        check_output({e.name, ".remainder"}, remainder32, e.r);
        check_output({e.name, ".div_by_zero"}, {31'b0, dz32}, {31'b0, e.dz});
        check_output({e.name, ".done_edge"}, edge_cnt, e.edge_idx);
        check_output({e.name, ".busy_at_done"}, {31'b0, busy32}, 32'd1);
      end
    end
  end

  always @(negedge clk) begin : monitor8
    exp_t e;
    if (!rst && done8) begin
      if (sb8.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected_done8: got done with q=0x%02h, expected no done", quotient8);
      end else begin
        e = sb8.pop_front();
        check_output({e.name, ".quotient"}, {24'b0, quotient8}, e.q);
        check_output({e.name, ".remainder"}, {24'b0, remainder8}, e.r);
        check_output({e.name, ".div_by_zero"}, {31'b0, dz8}, {31'b0, e.dz});
        check_output({e.name, ".done_edge"}, edge_cnt, e.edge_idx);
        check_output({e.name, ".busy_at_done"}, {31'b0, busy8}, 32'd1);
      end
    end
  end

  // Expectation is queued before the accepting edge so the monitor can never see done first.
  task automatic issue32(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic sop, input logic [31:0] eq, input logic [31:0] er,
                         input logic edz);
    exp_t e;
    @(negedge clk);
    start32    = 1'b1;
    dividend32 = a;
    divisor32  = b;
`ifdef DIVMOD_SIGNED_EN
    signed_op32 = sop;
`else
    if (sop) $display("[TB] note: %s requests signed_op in an unsigned build", name);
`endif
    e.name = name; e.q = eq; e.r = er; e.dz = edz;
    e.edge_idx = edge_cnt + 1 + ((b == 32'd0) ? 0 : 32);
    sb32.push_back(e);
    @(posedge clk);
    @(negedge clk);
    start32    = 1'b0;
    dividend32 = 32'hA5A5_5A5A;
    divisor32  = 32'h0;
  endtask

  task automatic wait_done32(input string name);
    int n = 0;
    while (sb32.size() != 0 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_output({name, ".pending32"}, sb32.size(), 32'd0);
    sb32.delete();
    @(negedge clk);
    #1;
    check_output({name, ".busy_after32"}, {31'b0, busy32}, 32'd0);
  endtask

  task automatic apply_stimulus(input string name, input logic [31:0] a, input logic [31:0] b,
                                input logic sop, input logic [31:0] eq, input logic [31:0] er,
                                input logic edz);
    issue32(name, a, b, sop, eq, er, edz);
    wait_done32(name);
  endtask

  task automatic apply_stimulus8(input string name, input logic [7:0] a, input logic [7:0] b,
                                 input logic [7:0] eq, input logic [7:0] er, input logic edz);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    start8 = 1'b1; dividend8 = a; divisor8 = b;
    e.name = name; e.q = {24'b0, eq}; e.r = {24'b0, er}; e.dz = edz;
    e.edge_idx = edge_cnt + 1 + ((b == 8'd0) ? 0 : 8);
    sb8.push_back(e);
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0; dividend8 = 8'h5A; divisor8 = 8'h00;
    while (sb8.size() != 0 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_output({name, ".pending8"}, sb8.size(), 32'd0);
    sb8.delete();
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  initial begin : stimulus
    int base;
    int n;
    exp_t e;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("reset.busy32", {31'b0, busy32}, 32'd0);
    check_output("reset.done32", {31'b0, done32}, 32'd0);
    check_output("reset.quotient32", quotient32, 32'd0);
    check_output("reset.remainder32", remainder32, 32'd0);
    check_output("reset.dz32", {31'b0, dz32}, 32'd0);
    check_output("reset.quotient8", {24'b0, quotient8}, 32'd0);
    rst = 1'b0;

    apply_stimulus("d100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
    apply_stimulus("d5_9", 32'd5, 32'd9, 1'b0, 32'd0, 32'd5, 1'b0);
    apply_stimulus("dmax_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0);
    apply_stimulus("dmax_msb", 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 32'd1, 32'h7FFF_FFFF, 1'b0);
    apply_stimulus("d0_5", 32'd0, 32'd5, 1'b0, 32'd0, 32'd0, 1'b0);
    apply_stimulus("div0", 32'd1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd1234, 1'b1);
    repeat (3) @(negedge clk);
    check_output("div0.dz_held", {31'b0, dz32}, 32'd1);
    check_output("div0.rem_held", remainder32, 32'd1234);
    apply_stimulus("after_div0", 32'd5, 32'd9, 1'b0, 32'd0, 32'd5, 1'b0);

    // A start pulse during CALC must neither restart nor add a second done.
    issue32("ignored_start", 32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 1'b0);
    repeat (5) @(negedge clk);
    start32 = 1'b1; dividend32 = 32'd77; divisor32 = 32'd7;
    @(negedge clk);
    start32 = 1'b0;
    wait_done32("ignored_start");
    repeat (40) @(negedge clk);

    // Reset at iteration 10 aborts the operation without a done.
    @(negedge clk);
    start32 = 1'b1; dividend32 = 32'd77777; divisor32 = 32'd11;
    @(posedge clk);
    @(negedge clk);
    start32 = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_output("abort.busy32", {31'b0, busy32}, 32'd0);
    check_output("abort.quotient32", quotient32, 32'd0);
    check_output("abort.remainder32", remainder32, 32'd0);
    check_output("abort.dz32", {31'b0, dz32}, 32'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    apply_stimulus("d50_6", 32'd50, 32'd6, 1'b0, 32'd8, 32'd2, 1'b0);

    apply_stimulus8("w8_200_3", 8'd200, 8'd3, 8'd66, 8'd2, 1'b0);
    apply_stimulus8("w8_255_255", 8'd255, 8'd255, 8'd1, 8'd0, 1'b0);
    apply_stimulus8("w8_div0", 8'd9, 8'd0, 8'hFF, 8'd9, 1'b1);

    // Held start gives an accept every WIDTH+2 edges.
    @(negedge clk);
    start8 = 1'b1; dividend8 = 8'd250; divisor8 = 8'd7;
    base = edge_cnt + 1;
    for (int k = 0; k < 3; k++) begin
      e.name = $sformatf("w8_b2b%0d", k);
      e.q = 32'd35; e.r = 32'd5; e.dz = 1'b0;
      e.edge_idx = base + k * 10 + 8;
      sb8.push_back(e);
    end
    while (edge_cnt < base + 20) @(negedge clk);
    start8 = 1'b0;
    n = 0;
    while (sb8.size() != 0 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_output("w8_b2b.pending8", sb8.size(), 32'd0);
    sb8.delete();
    repeat (15) @(negedge clk);

`ifdef DIVMOD_SIGNED_EN
    apply_stimulus("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    apply_stimulus("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0);
    apply_stimulus("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0);
    apply_stimulus("s_div0", 32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1);
    apply_stimulus("u_fff9_2", 32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1, 1'b0);
`endif

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
